conv_engine_buf: RTL

- Parametrised successor to the single-channel buffered convolution top.
- Owns three gbuffer instances (input, weights, result) and a host load/readback port, so buffers are loaded and results read from outside.
- Computes a multi-input-channel, multi-kernel, strided valid convolution with a signed MAC and saturating writeback.
- Sits between the host/DMA side and the result consumer.

---
 rtl/conv_pkg.sv | 48 ++++
 rtl/conv_addr_gen.sv | 84 ++++++++
 rtl/gbuffer.sv | 30 +++
 rtl/conv_engine_buf.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared encodings and size helpers for the buffered convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {
    SEL_INPUT   = 2'd0,
    SEL_WEIGHTS = 2'd1,
    SEL_RESULT  = 2'd2,
    SEL_NONE    = 2'd3
  } host_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } conv_state_e;

  function automatic int out_size(int i_size, int k_size, int stride);
    return (i_size - k_size) / stride + 1;
  endfunction

  function automatic int tap_count(int i_channels, int k_size);
    return i_channels * k_size * k_size;
  endfunction

  function automatic int out_count(int k_channels, int o);
    return k_channels * o * o;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int acc_w(int i_bit_width, int n);
    return 2 * i_bit_width + $clog2(n);
  endfunction

  function automatic longint sat_max(int rw);
    return (longint'(1) <<< (rw - 1)) - 1;
  endfunction

  function automatic longint sat_min(int rw);
    return -(longint'(1) <<< (rw - 1));
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Nested tap/output counters for the convolution walk; emits the three buffer addresses.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int I_SIZE     = 5,
  parameter int I_CHANNELS = 1,
  parameter int K_CHANNELS = 3,
  parameter int K_SIZE     = 3,
  parameter int STRIDE     = 1,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  tap_adv,
  input  logic                  out_adv,
  output logic [ADDR_WIDTH-1:0] in_addr,
  output logic [ADDR_WIDTH-1:0] wt_addr,
  output logic [ADDR_WIDTH-1:0] res_addr,
  output logic                  last_tap,
  output logic                  last_output
);

  localparam int O   = out_size(I_SIZE, K_SIZE, STRIDE);
  localparam int N   = tap_count(I_CHANNELS, K_SIZE);
  localparam int CW  = cnt_w(I_CHANNELS);
  localparam int KW  = cnt_w(K_SIZE);
  localparam int KCW = cnt_w(K_CHANNELS);
  localparam int OW  = cnt_w(O);

  logic [CW-1:0]  c;
  logic [KW-1:0]  kr, kc;
  logic [KCW-1:0] k;
  logic [OW-1:0]  orow, ocol;

  logic last_c, last_kr, last_kc, last_k, last_orow, last_ocol;

  assign last_c    = (c    == CW'(I_CHANNELS - 1));
  assign last_kr   = (kr   == KW'(K_SIZE - 1));
  assign last_kc   = (kc   == KW'(K_SIZE - 1));
  assign last_k    = (k    == KCW'(K_CHANNELS - 1));
  assign last_orow = (orow == OW'(O - 1));
  assign last_ocol = (ocol == OW'(O - 1));

  assign last_tap    = last_c & last_kr & last_kc;
  assign last_output = last_k & last_orow & last_ocol;

  // Tap counters wrap by themselves after the last tap, so each output starts at tap 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c <= '0; kr <= '0; kc <= '0;
      k <= '0; orow <= '0; ocol <= '0;
    end else if (clr) begin
      c <= '0; kr <= '0; kc <= '0;
      k <= '0; orow <= '0; ocol <= '0;
    end else begin
      if (tap_adv) begin
        kc <= last_kc ? '0 : kc + 1'b1;
        if (last_kc) begin
          kr <= last_kr ? '0 : kr + 1'b1;
          if (last_kr) c <= last_c ? '0 : c + 1'b1;
        end
      end
      if (out_adv) begin
        ocol <= last_ocol ? '0 : ocol + 1'b1;
        if (last_ocol) begin
          orow <= last_orow ? '0 : orow + 1'b1;
          if (last_orow) k <= last_k ? '0 : k + 1'b1;
        end
      end
    end
  end

  int in_row, in_col;

  always_comb begin
    in_row   = int'(orow) * STRIDE + int'(kr);
    in_col   = int'(ocol) * STRIDE + int'(kc);
    in_addr  = ADDR_WIDTH'(int'(c) * I_SIZE * I_SIZE + in_row * I_SIZE + in_col);
    wt_addr  = ADDR_WIDTH'(int'(k) * N + int'(c) * K_SIZE * K_SIZE + int'(kr) * K_SIZE + int'(kc));
    res_addr = ADDR_WIDTH'(int'(k) * O * O + int'(orow) * O + int'(ocol));
  end

endmodule

// File: rtl/gbuffer.sv
// Single-port buffer: registered read every cycle (1-cycle latency), synchronous write.
module gbuffer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int AIW = cnt_w(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  in_range;

  assign in_range = ({1'b0, addr} < (ADDR_WIDTH+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (in_range) begin
      rdata <= mem[addr[AIW-1:0]];
      if (we) mem[addr[AIW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/conv_engine_buf.sv
// Multi-channel, multi-kernel strided convolution over three host-loaded buffers.
// Define CONV_RELU_EN to clamp negative writeback values to zero.
module conv_engine_buf
  import conv_pkg::*;
#(
  parameter int I_BIT_WIDTH = 8,
  parameter int I_SIZE      = 5,
  parameter int I_CHANNELS  = 1,
  parameter int K_CHANNELS  = 3,
  parameter int K_SIZE      = 3,
  parameter int STRIDE      = 1,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic [1:0]               host_sel,
  input  logic                     host_wen,
  input  logic                     host_ren,
  input  logic [ADDR_WIDTH-1:0]    host_addr,
  input  logic [I_BIT_WIDTH-1:0]   host_wdata,
  output logic [2*I_BIT_WIDTH-1:0] host_rdata,
  output logic                     host_rvalid
);

  localparam int RW       = 2 * I_BIT_WIDTH;
  localparam int O        = out_size(I_SIZE, K_SIZE, STRIDE);
  localparam int N        = tap_count(I_CHANNELS, K_SIZE);
  localparam int T        = out_count(K_CHANNELS, O);
  localparam int ACC_W    = acc_w(I_BIT_WIDTH, N);
  localparam int IN_SPAN  = I_CHANNELS * I_SIZE * I_SIZE;
  localparam int WT_SPAN  = K_CHANNELS * N;
  localparam int RES_SPAN = T;

  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(RW));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(RW));

  if (I_SIZE < K_SIZE) begin : g_err_size
    $error("conv_engine_buf: I_SIZE must not be smaller than K_SIZE");
  end
  if (STRIDE < 1 || ((I_SIZE - K_SIZE) % STRIDE) != 0) begin : g_err_stride
    $error("conv_engine_buf: STRIDE must be >= 1 and divide I_SIZE-K_SIZE");
  end
  if (longint'(IN_SPAN) > (longint'(1) <<< ADDR_WIDTH) ||
      longint'(WT_SPAN) > (longint'(1) <<< ADDR_WIDTH) ||
      longint'(RES_SPAN) > (longint'(1) <<< ADDR_WIDTH)) begin : g_err_span
    $error("conv_engine_buf: a buffer span exceeds the address space");
  end

  conv_state_e state;

  logic                    idle, host_ok, host_wr, host_rd;
  logic                    tap_vld;
  logic signed [ACC_W-1:0] acc;
  logic signed [RW-1:0]    prod;
  logic [RW-1:0]           sat, wb;

  logic [ADDR_WIDTH-1:0]  in_addr, wt_addr, res_addr;
  logic                   last_tap, last_output;
  logic [I_BIT_WIDTH-1:0] in_rdata, wt_rdata;
  logic [RW-1:0]          res_rdata;

  // Start wins over a same-cycle host access; nothing from the host is honoured while running.
  assign idle    = (state == ST_IDLE);
  assign host_ok = idle & ~start;
  assign host_wr = host_ok & host_wen;
  assign host_rd = host_ok & host_ren & ~host_wen & (host_sel == SEL_RESULT);

  conv_addr_gen #(
    .I_SIZE     (I_SIZE),
    .I_CHANNELS (I_CHANNELS),
    .K_CHANNELS (K_CHANNELS),
    .K_SIZE     (K_SIZE),
    .STRIDE     (STRIDE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk         (clk),
    .rstn        (rstn),
    .clr         (idle & start),
    .tap_adv     (state == ST_FETCH),
    .out_adv     (state == ST_WRITE),
    .in_addr     (in_addr),
    .wt_addr     (wt_addr),
    .res_addr    (res_addr),
    .last_tap    (last_tap),
    .last_output (last_output)
  );

  gbuffer #(.DATA_WIDTH(I_BIT_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(IN_SPAN)) u_in_buf (
    .clk   (clk),
    .we    (host_wr & (host_sel == SEL_INPUT)),
    .addr  (idle ? host_addr : in_addr),
    .wdata (host_wdata),
    .rdata (in_rdata)
  );

  gbuffer #(.DATA_WIDTH(I_BIT_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(WT_SPAN)) u_wt_buf (
    .clk   (clk),
    .we    (host_wr & (host_sel == SEL_WEIGHTS)),
    .addr  (idle ? host_addr : wt_addr),
    .wdata (host_wdata),
    .rdata (wt_rdata)
  );

  gbuffer #(.DATA_WIDTH(RW), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(RES_SPAN)) u_res_buf (
    .clk   (clk),
    .we    (state == ST_WRITE),
    .addr  (idle ? host_addr : res_addr),
    .wdata (wb),
    .rdata (res_rdata)
  );

  assign prod       = RW'($signed(in_rdata)) * RW'($signed(wt_rdata));
  assign host_rdata = host_rvalid ? res_rdata : '0;

  always_comb begin
    sat = acc[RW-1:0];
    if (acc > ACC_MAX)      sat = ACC_MAX[RW-1:0];
    else if (acc < ACC_MIN) sat = ACC_MIN[RW-1:0];
`ifdef CONV_RELU_EN
    wb = sat[RW-1] ? '0 : sat;
`else
    wb = sat;
`endif
  end

  // Buffer data lags its address by one cycle, so tap_vld marks the cycle a product is ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      tap_vld     <= 1'b0;
      acc         <= '0;
      host_rvalid <= 1'b0;
    end else begin
      done        <= 1'b0;
      host_rvalid <= host_rd;
      tap_vld     <= (state == ST_FETCH);
      if (tap_vld) acc <= acc + ACC_W'(prod);
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_FETCH;
            busy  <= 1'b1;
            acc   <= '0;
          end
        end
        ST_FETCH: if (last_tap) state <= ST_DRAIN;
        ST_DRAIN: state <= ST_WRITE;
        ST_WRITE: begin
          acc <= '0;
          if (last_output) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
